vector_ram_arbiter: RTL and testbench
=====================================

VECTOR_RAM_ARBITER -- requirements
Module: vector_ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters sharing one vector RAM, 2..8.
REQ-002 SHALL have parameter PARALLELISM, default 4: lanes per access.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: bits per lane.
REQ-004 SHALL have parameter VECTOR_LENGTH, default 32: words in the RAM. ADDR_WIDTH SHALL be the localparam $clog2(VECTOR_LENGTH).
REQ-005 SHALL have parameter TAG_DEPTH, default 4: maximum number of outstanding reads, a power of 2.
REQ-006 SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-007 SHALL have the following requester-side ports:
- req_valid, input, NUM_REQ bits: request per requester.
- req_ready, output, NUM_REQ bits: request accepted.
- req_write, input, NUM_REQ bits: 1 = write, 0 = read.
- req_addr, input, [NUM_REQ][PARALLELISM] x ADDR_WIDTH: lane addresses.
- req_wdata, input, [NUM_REQ][PARALLELISM] x DATA_WIDTH: lane write data.
- rsp_valid, output, NUM_REQ bits: read data valid for that requester.
- rsp_ready, input, NUM_REQ bits: requester accepts the response.
- rsp_rdata, output, [PARALLELISM] x DATA_WIDTH: shared read data bus.
REQ-008 SHALL have the following RAM-side ports:
- ram_valid, output, 1 bit.
- ram_ready, input, 1 bit.
- ram_write, output, 1 bit.
- ram_addr, output, [PARALLELISM] x ADDR_WIDTH.
- ram_wdata, output, [PARALLELISM] x DATA_WIDTH.
- ram_rdata, input, [PARALLELISM] x DATA_WIDTH.
- ram_rvalid, input, 1 bit.
- ram_rready, output, 1 bit.

Function
REQ-009 SHALL arbitrate round-robin. The search starts at the requester after the last granted one. After reset the search starts at requester 0.
REQ-010 SHALL use a two-state FSM:
- ARB: a grant is chosen combinationally from req_valid.
- HOLD: entered when ram_valid=1 and ram_ready=0. The grant index, ram_write, ram_addr and ram_wdata are frozen until ram_ready=1, then the FSM returns to ARB.
REQ-011 SHALL drive the grant's req_ready = ram_ready, and all other req_ready = 0. Zero added latency: a request transfers on the same cycle as the RAM handshake.
REQ-012 SHALL advance the round-robin pointer only when a handshake completes (ram_valid & ram_ready).
REQ-013 SHALL push the granted index (width $clog2(NUM_REQ)) into the tag FIFO for each accepted read. Writes push nothing and produce no response.
REQ-014 SHALL hold off a read when the tag FIFO is full: ram_valid=0 for that read. Writes are still granted.
REQ-015 SHALL route responses in order: rsp_valid[head tag] = ram_rvalid, ram_rready = rsp_ready[head tag], rsp_rdata = ram_rdata. The tag pops on ram_rvalid & ram_rready.
REQ-016 SHALL drive ram_rready=0 and all rsp_valid=0 while the tag FIFO is empty. A ram_rvalid with no tag is an error; it SHALL set the sticky internal flag err_orphan and not be routed.
REQ-017 SHALL support a simultaneous push and pop on a full FIFO. In that case count is unchanged and the push is accepted.
REQ-018 SHALL wrap the FIFO pointers modulo TAG_DEPTH.
REQ-019 SHALL pass one-hot grant data without modifying it. Every lane is forwarded bit-exact.

Reset
REQ-020 SHALL apply asynchronous rst_n low to: FSM=ARB, pointer=0, FIFO empty, err_orphan=0.
REQ-021 SHALL hold these outputs at 0 during reset: req_ready, rsp_valid, ram_valid, ram_write, ram_rready. ram_addr, ram_wdata and rsp_rdata SHALL read 0.
REQ-022 SHALL discard any transfer in HOLD and any outstanding tags when reset is asserted mid-operation. No response is routed after the reset.

Structure
REQ-023 SHALL place the FSM state enum and the tag-width function in vector_ram_pkg.
REQ-024 SHALL instantiate one sub-module, rr_arbiter: a NUM_REQ one-hot round-robin with a pointer-advance enable. The tag FIFO is inline.

Verification
REQ-025 SHALL be verified with these directed scenarios:
- Both requesters hold continuous reads with ram_ready=1 -> grants alternate 0,1,0,1 and responses return to 0,1,0,1 in order.
- Requester 1 writes, ram_ready held 0 for 3 cycles, requester 0 asserts mid-stall -> ram_addr and ram_wdata stable for 3 cycles; requester 0 granted on the next cycle.
- Requester 0 issues 4 reads with no ram_rvalid, TAG_DEPTH=4 -> 5th read has ram_valid=0; a write from requester 1 is still accepted.
- FIFO full, ram_rvalid & ram_rready and a new read handshake in the same cycle -> count stays 4 and the tag order is preserved.
- rsp_ready[head]=0 with ram_rvalid=1 -> ram_rready=0 and data held; other requesters keep issuing.
- rst_n pulsed low in HOLD with 2 tags outstanding -> all outputs 0 immediately; subsequent ram_rvalid sets err_orphan.

Source files
------------

// File: rtl/vector_ram_pkg.sv
// ============================================================================
// Module      : vector_ram_pkg
// Description : Shared FSM state encoding and tag-width helper for the
//               vector RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vector_ram_pkg;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  // Requester index width; never narrower than one bit.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : One-hot round-robin arbiter; the search starts one past the
//               last granted requester and advances only when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import vector_ram_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = tag_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] scan;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    scan    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!gnt_any && req[scan]) begin
        gnt_any   = 1'b1;
        gnt[scan] = 1'b1;
        gnt_idx   = scan;
      end
    end
  end

  assign ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (adv_en && gnt_any) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vector_ram_arbiter.sv
// ============================================================================
// Module      : vector_ram_arbiter
// Description : Shares one vector RAM among NUM_REQ requesters with round-robin
//               grant, stall hold and in-order read response routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_ram_arbiter
  import vector_ram_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int PARALLELISM   = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int VECTOR_LENGTH = 32,
  parameter int TAG_DEPTH     = 4,
  localparam int ADDR_WIDTH   = $clog2(VECTOR_LENGTH)
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [NUM_REQ-1:0]                               req_valid,
  output logic [NUM_REQ-1:0]                               req_ready,
  input  logic [NUM_REQ-1:0]                               req_write,
  input  logic [NUM_REQ-1:0][PARALLELISM-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0][PARALLELISM-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                               rsp_valid,
  input  logic [NUM_REQ-1:0]                               rsp_ready,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0]           rsp_rdata,
  output logic                                             ram_valid,
  input  logic                                             ram_ready,
  output logic                                             ram_write,
  output logic [PARALLELISM-1:0][ADDR_WIDTH-1:0]           ram_addr,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0]           ram_wdata,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0]           ram_rdata,
  input  logic                                             ram_rvalid,
  output logic                                             ram_rready
);

  localparam int TAG_W = tag_width(NUM_REQ);
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  arb_state_e state_q, state_d;

  logic [NUM_REQ-1:0]                         hold_gnt_q;
  logic                                       hold_write_q;
  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0]     hold_addr_q;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0]     hold_wdata_q;

  logic [NUM_REQ-1:0]                         arb_req;
  logic [NUM_REQ-1:0]                         gnt;
  logic [TAG_W-1:0]                           gnt_idx;
  logic                                       gnt_any;
  logic                                       live_write;
  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0]     live_addr;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0]     live_wdata;

  logic [TAG_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_full, fifo_empty, push, pop, read_ok;
  logic             err_orphan;

  assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_tag   = tag_mem[rd_ptr_q];

  // A read may issue into a full FIFO only when a tag leaves in the same cycle.
  assign read_ok = !fifo_full || pop;

  always_comb begin
    arb_req = '0;
    if (rst_n) begin
      arb_req = (state_q == ST_HOLD) ? hold_gnt_q
                                     : (req_valid & (req_write | {NUM_REQ{read_ok}}));
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .adv_en  (ram_ready),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    live_write = 1'b0;
    live_addr  = '0;
    live_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        live_write = live_write | req_write[i];
        live_addr  = live_addr  | req_addr[i];
        live_wdata = live_wdata | req_wdata[i];
      end
    end
  end

  assign ram_valid = gnt_any;
  assign ram_write = (state_q == ST_HOLD) ? hold_write_q : live_write;
  assign ram_addr  = (state_q == ST_HOLD) ? hold_addr_q  : live_addr;
  assign ram_wdata = (state_q == ST_HOLD) ? hold_wdata_q : live_wdata;
  assign req_ready = gnt & {NUM_REQ{ram_ready}};

  assign push = gnt_any && ram_ready && !ram_write;
  assign pop  = ram_rvalid && ram_rready;

  always_comb begin
    rsp_valid  = '0;
    ram_rready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!fifo_empty && (head_tag == TAG_W'(i))) begin
        rsp_valid[i] = ram_rvalid;
        ram_rready   = rsp_ready[i];
      end
    end
  end

  assign rsp_rdata = rst_n ? ram_rdata : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:  if (gnt_any && !ram_ready) state_d = ST_HOLD;
      ST_HOLD: if (ram_ready)             state_d = ST_ARB;
      default:                            state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      hold_gnt_q   <= '0;
      hold_write_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ARB && gnt_any && !ram_ready) begin
        hold_gnt_q   <= gnt;
        hold_write_q <= live_write;
        hold_addr_q  <= live_addr;
        hold_wdata_q <= live_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q] <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (ram_rvalid && fifo_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_ram_arbiter.sv
// ============================================================================
// Module      : tb_vector_ram_arbiter
// Description : Directed table-driven bench for vector_ram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_ram_arbiter;

  localparam int NR = 2;
  localparam int P  = 4;
  localparam int DW = 32;
  localparam int VL = 32;
  localparam int TD = 4;
  localparam int AW = 5;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NR-1:0]                req_valid, req_ready, req_write;
  logic [NR-1:0][P-1:0][AW-1:0] req_addr;
  logic [NR-1:0][P-1:0][DW-1:0] req_wdata;
  logic [NR-1:0]                rsp_valid, rsp_ready;
  logic [P-1:0][DW-1:0]         rsp_rdata;
  logic                         ram_valid, ram_ready, ram_write;
  logic [P-1:0][AW-1:0]         ram_addr;
  logic [P-1:0][DW-1:0]         ram_wdata, ram_rdata;
  logic                         ram_rvalid, ram_rready;

  int n_chk = 0;
  int n_err = 0;
  int seed  = 0;

  always #5 clk = ~clk;

  vector_ram_arbiter #(
    .NUM_REQ       (NR),
    .PARALLELISM   (P),
    .DATA_WIDTH    (DW),
    .VECTOR_LENGTH (VL),
    .TAG_DEPTH     (TD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .ram_valid  (ram_valid),
    .ram_ready  (ram_ready),
    .ram_write  (ram_write),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_rvalid (ram_rvalid),
    .ram_rready (ram_rready)
  );

  typedef struct {
    logic [1:0] rv;
    logic [1:0] rw;
    logic       rdy;
    logic       rvalid;
    logic [1:0] rsprdy;
    logic [1:0] e_rr;
    logic       e_val;
    logic       e_wr;
    int         e_g;
    logic [1:0] e_rsp;
    logic       e_rrdy;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [AW-1:0] addr_val(int r, int l, int alt);
    return AW'(r * 8 + l + 1 + alt * 16);
  endfunction

  function automatic logic [DW-1:0] data_val(int r, int l, int alt);
    return 32'hA000_0000 + 32'(r * 256 + l + alt * 65536);
  endfunction

  function automatic logic [P*AW-1:0] exp_addr(int g);
    logic [P-1:0][AW-1:0] bus;
    for (int l = 0; l < P; l++) bus[l] = addr_val(g, l, 0);
    return bus;
  endfunction

  function automatic logic [P*DW-1:0] exp_wdata(int g);
    logic [P-1:0][DW-1:0] bus;
    for (int l = 0; l < P; l++) bus[l] = data_val(g, l, 0);
    return bus;
  endfunction

  task automatic set_req(input int alt1);
    for (int r = 0; r < NR; r++) begin
      for (int l = 0; l < P; l++) begin
        req_addr[r][l]  = addr_val(r, l, (r == 1) ? alt1 : 0);
        req_wdata[r][l] = data_val(r, l, (r == 1) ? alt1 : 0);
      end
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic [1:0] rw, input logic rdy,
                       input logic rvalid, input logic [1:0] rsprdy);
    req_valid  = rv;
    req_write  = rw;
    ram_ready  = rdy;
    ram_rvalid = rvalid;
    rsp_ready  = rsprdy;
    seed++;
    for (int l = 0; l < P; l++) ram_rdata[l] = 32'hD000_0000 + 32'(seed * 16 + l);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_io(input string tag, input logic [1:0] e_rr, input logic e_val,
                           input logic e_wr, input int e_g, input logic [1:0] e_rsp,
                           input logic e_rrdy);
    #1;
    chk({tag, ".req_ready"}, req_ready, e_rr);
    chk({tag, ".ram_valid"}, ram_valid, e_val);
    if (e_val) begin
      chk({tag, ".ram_write"}, ram_write, e_wr);
      chk({tag, ".ram_addr"}, ram_addr, exp_addr(e_g));
      chk({tag, ".ram_wdata"}, ram_wdata, exp_wdata(e_g));
    end
    chk({tag, ".rsp_valid"}, rsp_valid, e_rsp);
    chk({tag, ".ram_rready"}, ram_rready, e_rrdy);
    chk({tag, ".rsp_rdata"}, rsp_rdata, ram_rdata);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".req_ready"}, req_ready, 0);
    chk({tag, ".rsp_valid"}, rsp_valid, 0);
    chk({tag, ".ram_valid"}, ram_valid, 0);
    chk({tag, ".ram_write"}, ram_write, 0);
    chk({tag, ".ram_rready"}, ram_rready, 0);
    chk({tag, ".ram_addr"}, ram_addr, 0);
    chk({tag, ".ram_wdata"}, ram_wdata, 0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 0);
  endtask

  // Reset is entered with every requester and the RAM side active.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b11, 2'b01, 1'b1, 1'b1, 2'b11);
    #3;
    check_zero("reset");
    drive(2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset.err_orphan", dut.err_orphan, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b11, 2'b01, 1'b1, 1'b0,  0, 2'b00, 1'b0};
    tbl[1]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b11, 2'b10, 1'b1, 1'b0,  1, 2'b00, 1'b1};
    tbl[2]  = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0,  0, 2'b01, 1'b1};
    tbl[3]  = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1, 1'b0,  1, 2'b10, 1'b1};
    tbl[4]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, -1, 2'b01, 1'b1};
    tbl[5]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, -1, 2'b10, 1'b1};
    tbl[6]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, -1, 2'b00, 1'b0};
    tbl[7]  = '{2'b10, 2'b10, 1'b1, 1'b0, 2'b11, 2'b10, 1'b1, 1'b1,  1, 2'b00, 1'b0};
    tbl[8]  = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b11, 2'b01, 1'b1, 1'b0,  0, 2'b00, 1'b0};
    tbl[9]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, -1, 2'b01, 1'b1};
    tbl[10] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, -1, 2'b00, 1'b0};

    set_req(0);
    do_reset();

    // Alternating reads with in-order returns, then a write that pushes no tag.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rv, tbl[i].rw, tbl[i].rdy, tbl[i].rvalid, tbl[i].rsprdy);
      expect_io($sformatf("vec%0d", i), tbl[i].e_rr, tbl[i].e_val, tbl[i].e_wr,
                tbl[i].e_g, tbl[i].e_rsp, tbl[i].e_rrdy);
      tick();
    end

    // Write stalled three cycles; requester 1 changes its payload meanwhile.
    do_reset();
    drive(2'b10, 2'b10, 1'b0, 1'b0, 2'b11);
    expect_io("stall.c0", 2'b00, 1'b1, 1'b1, 1, 2'b00, 1'b0);
    tick();
    set_req(1);
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, 2'b10, 1'b0, 1'b0, 2'b11);
      expect_io($sformatf("stall.hold%0d", k), 2'b00, 1'b1, 1'b1, 1, 2'b00, 1'b0);
      tick();
    end
    drive(2'b11, 2'b10, 1'b1, 1'b0, 2'b11);
    expect_io("stall.release", 2'b10, 1'b1, 1'b1, 1, 2'b00, 1'b0);
    tick();
    set_req(0);
    drive(2'b11, 2'b10, 1'b1, 1'b0, 2'b11);
    expect_io("stall.next", 2'b01, 1'b1, 1'b0, 0, 2'b00, 1'b0);
    tick();

    // Four outstanding reads fill the FIFO; a fifth read waits, a write proceeds.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 2'b00, 1'b1, 1'b0, 2'b11);
      expect_io($sformatf("full.rd%0d", k), 2'b01, 1'b1, 1'b0, 0, 2'b00, (k > 0));
      tick();
    end
    drive(2'b01, 2'b00, 1'b1, 1'b0, 2'b11);
    expect_io("full.blocked", 2'b00, 1'b0, 1'b0, -1, 2'b00, 1'b1);
    tick();
    drive(2'b11, 2'b10, 1'b1, 1'b0, 2'b11);
    expect_io("full.write", 2'b10, 1'b1, 1'b1, 1, 2'b00, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 2'b00, 1'b1, 1'b1, 2'b11);
      expect_io($sformatf("full.drain%0d", k), 2'b00, 1'b0, 1'b0, -1, 2'b01, 1'b1);
      tick();
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0, 2'b11);
    expect_io("full.empty", 2'b00, 1'b0, 1'b0, -1, 2'b00, 1'b0);
    tick();

    // Full FIFO with a pop and a push in the same cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 2'b00, 1'b1, 1'b0, 2'b11);
      expect_io($sformatf("swap.fill%0d", k), (k % 2 == 1) ? 2'b10 : 2'b01, 1'b1, 1'b0,
                k % 2, 2'b00, (k > 0));
      tick();
    end
    drive(2'b11, 2'b00, 1'b1, 1'b1, 2'b11);
    expect_io("swap.both", 2'b01, 1'b1, 1'b0, 0, 2'b01, 1'b1);
    tick();
    drive(2'b11, 2'b00, 1'b1, 1'b0, 2'b11);
    expect_io("swap.stillfull", 2'b00, 1'b0, 1'b0, -1, 2'b00, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 2'b00, 1'b1, 1'b1, 2'b11);
      expect_io($sformatf("swap.drain%0d", k), 2'b00, 1'b0, 1'b0, -1,
                (k % 2 == 0) ? 2'b10 : 2'b01, 1'b1);
      tick();
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0, 2'b11);
    expect_io("swap.empty", 2'b00, 1'b0, 1'b0, -1, 2'b00, 1'b0);
    tick();

    // Head requester refuses its response while the other keeps issuing.
    do_reset();
    drive(2'b01, 2'b00, 1'b1, 1'b0, 2'b11);
    expect_io("bp.rd0", 2'b01, 1'b1, 1'b0, 0, 2'b00, 1'b0);
    tick();
    drive(2'b10, 2'b00, 1'b1, 1'b1, 2'b10);
    expect_io("bp.rd1", 2'b10, 1'b1, 1'b0, 1, 2'b01, 1'b0);
    tick();
    drive(2'b10, 2'b10, 1'b1, 1'b1, 2'b10);
    expect_io("bp.wr1", 2'b10, 1'b1, 1'b1, 1, 2'b01, 1'b0);
    tick();
    drive(2'b00, 2'b00, 1'b1, 1'b1, 2'b11);
    expect_io("bp.pop0", 2'b00, 1'b0, 1'b0, -1, 2'b01, 1'b1);
    tick();
    drive(2'b00, 2'b00, 1'b1, 1'b1, 2'b11);
    expect_io("bp.pop1", 2'b00, 1'b0, 1'b0, -1, 2'b10, 1'b1);
    tick();
    drive(2'b00, 2'b00, 1'b1, 1'b0, 2'b11);
    expect_io("bp.empty", 2'b00, 1'b0, 1'b0, -1, 2'b00, 1'b0);
    tick();

    // Reset asserted while a read is held with two tags outstanding.
    do_reset();
    drive(2'b01, 2'b00, 1'b1, 1'b0, 2'b11);
    expect_io("mid.rd0", 2'b01, 1'b1, 1'b0, 0, 2'b00, 1'b0);
    tick();
    drive(2'b10, 2'b00, 1'b1, 1'b0, 2'b11);
    expect_io("mid.rd1", 2'b10, 1'b1, 1'b0, 1, 2'b00, 1'b1);
    tick();
    drive(2'b01, 2'b00, 1'b0, 1'b0, 2'b11);
    expect_io("mid.stall", 2'b00, 1'b1, 1'b0, 0, 2'b00, 1'b1);
    tick();
    drive(2'b01, 2'b00, 1'b0, 1'b0, 2'b11);
    expect_io("mid.hold", 2'b00, 1'b1, 1'b0, 0, 2'b00, 1'b1);
    #2;
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 1'b1, 1'b1, 2'b11);
    #1;
    check_zero("mid.rst");
    @(negedge clk);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 2'b11);
    rst_n = 1'b1;
    chk("mid.err_before", dut.err_orphan, 0);
    tick();
    drive(2'b00, 2'b00, 1'b1, 1'b1, 2'b11);
    expect_io("mid.orphan", 2'b00, 1'b0, 1'b0, -1, 2'b00, 1'b0);
    tick();
    chk("mid.err_after", dut.err_orphan, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
